// File: rtl/espsid_pkg.sv
// Shared definitions for the multi-SID writer: bus widths, writer FSM
// states and frame-size helper.
package espsid_pkg;

  localparam int SID_ADDR_W   = 5;
  localparam int SID_MAX_REGS = 25;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WAIT_FALL,
    HOLD,
    DONE
  } writer_state_e;

  // Number of bytes in one complete frame (chip-major layout).
  function automatic int frame_size(input int num_chips, input int num_regs);
    return num_chips * num_regs;
  endfunction

endpackage

// File: rtl/sid_clk_gen.sv
// phi2 generator: divides clk by 2*CLK_DIV and marks each sid_clk edge with
// a one-cycle strobe that is coincident with the registered toggle.
module sid_clk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic sid_clk,
  output logic phi_rise,
  output logic phi_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sid_clk_q, sid_clk_d;
  logic             toggle;

  // Divider next-state and edge strobes.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    toggle    = (div_q == DIV_LAST);
    div_d     = toggle ? '0 : div_q + 1'b1;
    sid_clk_d = toggle ? ~sid_clk_q : sid_clk_q;
    phi_rise  = toggle && !sid_clk_q;
    phi_fall  = toggle && sid_clk_q;
  end

  // Divider and phi2 registers.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs before any of them update within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      sid_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      sid_clk_q <= sid_clk_d;
    end
  end

  assign sid_clk = sid_clk_q;

endmodule

// File: rtl/sid_multi_writer.sv
// Multi-SID glue stage: captures SPI frame bytes into a ping-pong buffer and
// writes them to NUM_CHIPS SIDs sharing one address/data bus, one chip-select
// per chip. Also generates phi2 and the SID reset.
// Build option: define SID_DELTA_EN to keep a shadow copy of the last values
// written and send only registers that changed; without it every frame
// rewrites all registers.
module sid_multi_writer
  import espsid_pkg::*;
#(
  parameter int NUM_CHIPS      = 2,   // 1..4, frame layout is chip-major
  parameter int NUM_REGS       = 25,  // 1..SID_MAX_REGS
  parameter int CLK_DIV        = 8,   // clk cycles per phi2 half-period, >= 2
  parameter int RST_PHI_CYCLES = 16   // phi2 periods of SID reset, >= 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  input  logic                  frame_end,
  output logic                  sid_clk,
  output logic [SID_ADDR_W-1:0] sid_addr,
  output logic [7:0]            sid_data,
  output logic [NUM_CHIPS-1:0]  sid_cs_n,
  output logic                  sid_rw,
  output logic                  sid_rst_n,
  output logic                  busy,
  output logic                  frame_drop,
  output logic                  frame_short
);

  localparam int FRAME  = frame_size(NUM_CHIPS, NUM_REGS);
  localparam int CNT_W  = $clog2(FRAME + 1);
  localparam int IDX_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int CHIP_W = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
  localparam int RST_W  = $clog2(RST_PHI_CYCLES + 1);

  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(FRAME);
  localparam logic [SID_ADDR_W-1:0] LAST_REG  = SID_ADDR_W'(NUM_REGS - 1);
  localparam logic [CHIP_W-1:0]     LAST_CHIP = CHIP_W'(NUM_CHIPS - 1);
  localparam logic [RST_W-1:0]      RST_LAST  = RST_W'(RST_PHI_CYCLES - 1);

  // ---------------------------------------------------------------------
  // phi2 generation
  // ---------------------------------------------------------------------
  logic phi_fall;
  logic phi_rise_unused;  // the writer only acts on falling edges

  sid_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .sid_clk  (sid_clk),
    .phi_rise (phi_rise_unused),
    .phi_fall (phi_fall)
  );

  // ---------------------------------------------------------------------
  // SID reset: held low for RST_PHI_CYCLES falling phi2 edges
  // ---------------------------------------------------------------------
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             sid_rst_n_q, sid_rst_n_d;

  // Count phi2 falling edges until the SID reset is released.
  always_comb begin
    rst_cnt_d   = rst_cnt_q;
    sid_rst_n_d = sid_rst_n_q;
    if (!sid_rst_n_q && phi_fall) begin
      if (rst_cnt_q == RST_LAST) sid_rst_n_d = 1'b1;
      else                       rst_cnt_d   = rst_cnt_q + 1'b1;
    end
  end

  // SID reset registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q   <= '0;
      sid_rst_n_q <= 1'b0;
    end else begin
      rst_cnt_q   <= rst_cnt_d;
      sid_rst_n_q <= sid_rst_n_d;
    end
  end

  // ---------------------------------------------------------------------
  // Capture and frame accept
  // ---------------------------------------------------------------------
  logic [7:0]       bank_q [2][FRAME];
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             fill_bank_q, fill_bank_d;
  logic             frame_drop_q, frame_drop_d;
  logic             frame_short_q, frame_short_d;
  logic             cap_we;
  logic [IDX_W-1:0] cap_idx;
  logic             frame_full;
  logic             writer_ready;
  logic             swap;
  writer_state_e    state_q, state_d;

  // Byte counter, bank selection and accept/drop/short decisions.
  // A byte arriving with frame_end is counted before the length check.
  // A full frame arriving while the SIDs are still in reset is treated like
  // one arriving while busy: the writer cannot take it, so it is dropped.
  always_comb begin
    cap_we        = byte_valid && (cnt_q < FULL_CNT);
    cap_idx       = cnt_q[IDX_W-1:0];
    cnt_inc       = cap_we ? cnt_q + 1'b1 : cnt_q;
    frame_full    = (cnt_inc == FULL_CNT);
    cnt_d         = frame_end ? '0 : cnt_inc;
    writer_ready  = (state_q == IDLE) && sid_rst_n_q;
    swap          = frame_end && frame_full && writer_ready;
    frame_drop_d  = frame_end && frame_full && !writer_ready;
    frame_short_d = frame_end && !frame_full;
    fill_bank_d   = swap ? ~fill_bank_q : fill_bank_q;
  end

  // Capture control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      fill_bank_q   <= 1'b0;
      frame_drop_q  <= 1'b0;
      frame_short_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      fill_bank_q   <= fill_bank_d;
      frame_drop_q  <= frame_drop_d;
      frame_short_q <= frame_short_d;
    end
  end

  // Frame bank storage.
  // NOTE: the byte storage has no reset; its contents are only read after a
  // complete frame has been written into it, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (cap_we) bank_q[fill_bank_q][cap_idx] <= byte_in;
  end

  // ---------------------------------------------------------------------
  // Writer
  // ---------------------------------------------------------------------
  logic [CHIP_W-1:0]     chip_q, chip_d;
  logic [SID_ADDR_W-1:0] reg_q, reg_d;
  logic                  busy_q, busy_d;
  logic [SID_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  rw_q, rw_d;
  logic [NUM_CHIPS-1:0]  cs_n_q, cs_n_d;
  logic [IDX_W-1:0]      rd_idx;
  logic [7:0]            rd_val;
  logic                  last_pos;
  logic                  need_write;

`ifdef SID_DELTA_EN
  logic [7:0] shadow_q [FRAME];
  logic       shadow_valid_q, shadow_valid_d;
  logic       shadow_we;
`endif

  // Current register value from the active bank and the change test.
  always_comb begin
    rd_idx   = IDX_W'(int'(chip_q) * NUM_REGS + int'(reg_q));
    rd_val   = bank_q[~fill_bank_q][rd_idx];
    last_pos = (chip_q == LAST_CHIP) && (reg_q == LAST_REG);
`ifdef SID_DELTA_EN
    need_write = !shadow_valid_q || (rd_val != shadow_q[rd_idx]);
`else
    need_write = 1'b1;
`endif
  end

  // Writer next-state and bus outputs.
  always_comb begin
    state_d = state_q;
    chip_d  = chip_q;
    reg_d   = reg_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    cs_n_d  = cs_n_q;
`ifdef SID_DELTA_EN
    shadow_we      = 1'b0;
    shadow_valid_d = shadow_valid_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (swap) begin
          busy_d  = 1'b1;
          chip_d  = '0;
          reg_d   = '0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (need_write) begin
          state_d = WAIT_FALL;
        end else if (last_pos) begin
          state_d = DONE;
        end else if (reg_q == LAST_REG) begin
          reg_d  = '0;
          chip_d = chip_q + 1'b1;
        end else begin
          reg_d = reg_q + 1'b1;
        end
      end

      // Present address/data/select at a falling phi2 edge so they are
      // stable for the whole low phase before the SID latches.
      WAIT_FALL: begin
        if (phi_fall) begin
          addr_d         = reg_q;
          data_d         = rd_val;
          rw_d           = 1'b0;
          cs_n_d[chip_q] = 1'b0;
          state_d        = HOLD;
        end
      end

      // The SID latches at this falling edge; release select, keep the bus.
      HOLD: begin
        if (phi_fall) begin
          cs_n_d = '1;
          rw_d   = 1'b1;
`ifdef SID_DELTA_EN
          shadow_we = 1'b1;
`endif
          if (last_pos) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            if (reg_q == LAST_REG) begin
              reg_d  = '0;
              chip_d = chip_q + 1'b1;
            end else begin
              reg_d = reg_q + 1'b1;
            end
          end
        end
      end

      DONE: begin
`ifdef SID_DELTA_EN
        shadow_valid_d = 1'b1;
`endif
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Writer state and bus registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chip_q  <= '0;
      reg_q   <= '0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b1;
      cs_n_q  <= '1;
    end else begin
      state_q <= state_d;
      chip_q  <= chip_d;
      reg_q   <= reg_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      cs_n_q  <= cs_n_d;
    end
  end

`ifdef SID_DELTA_EN
  // Shadow validity: cleared by reset so the next frame rewrites everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_valid_q <= 1'b0;
    else        shadow_valid_q <= shadow_valid_d;
  end

  // Shadow copy of the value last written to each register.
  always_ff @(posedge clk) begin
    if (shadow_we) shadow_q[rd_idx] <= rd_val;
  end
`endif

  assign sid_addr    = addr_q;
  assign sid_data    = data_q;
  assign sid_cs_n    = cs_n_q;
  assign sid_rw      = rw_q;
  assign sid_rst_n   = sid_rst_n_q;
  assign busy        = busy_q;
  assign frame_drop  = frame_drop_q;
  assign frame_short = frame_short_q;

endmodule

// File: tb/tb_sid_multi_writer.sv
// Self-checking bench for sid_multi_writer (CLK_DIV=4, 2 chips x 25 regs).
// A frame-level model predicts the ordered list of SID writes; a monitor
// decodes every chip-select pulse on the bus and compares it in order.
module tb_sid_multi_writer;

  localparam int NUM_CHIPS      = 2;
  localparam int NUM_REGS       = 25;
  localparam int CLK_DIV        = 4;
  localparam int RST_PHI_CYCLES = 16;
  localparam int FRAME          = NUM_CHIPS * NUM_REGS;
  localparam int WR_LEN         = 2 * CLK_DIV;
`ifdef SID_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] chip;
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 byte_valid = 1'b0;
  logic [7:0]           byte_in = 8'h00;
  logic                 frame_end = 1'b0;
  logic                 sid_clk;
  logic [4:0]           sid_addr;
  logic [7:0]           sid_data;
  logic [NUM_CHIPS-1:0] sid_cs_n;
  logic                 sid_rw;
  logic                 sid_rst_n;
  logic                 busy;
  logic                 frame_drop;
  logic                 frame_short;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t        exp_q[$];
  wr_t        obs_q[$];
  logic [7:0] fbuf [64];
  logic [7:0] m_shadow [FRAME];
  bit         m_valid = 1'b0;

  sid_multi_writer #(
    .NUM_CHIPS      (NUM_CHIPS),
    .NUM_REGS       (NUM_REGS),
    .CLK_DIV        (CLK_DIV),
    .RST_PHI_CYCLES (RST_PHI_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_valid  (byte_valid),
    .byte_in     (byte_in),
    .frame_end   (frame_end),
    .sid_clk     (sid_clk),
    .sid_addr    (sid_addr),
    .sid_data    (sid_data),
    .sid_cs_n    (sid_cs_n),
    .sid_rw      (sid_rw),
    .sid_rst_n   (sid_rst_n),
    .busy        (busy),
    .frame_drop  (frame_drop),
    .frame_short (frame_short)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wr_t mk(input int chip, input int addr, input int data);
    wr_t w;
    w.chip = 2'(chip);
    w.addr = 5'(addr);
    w.data = 8'(data);
    return w;
  endfunction

  // Frame-level model: which registers a newly accepted frame must write.
  int m_pushed;
  task automatic model_accept();
    m_pushed = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (!DELTA || !m_valid || fbuf[i] != m_shadow[i]) begin
        exp_q.push_back(mk(i / NUM_REGS, i % NUM_REGS, int'(fbuf[i])));
        m_shadow[i] = fbuf[i];
        m_pushed++;
      end
    end
    m_valid = 1'b1;
  endtask

  // Bus monitor: decodes each chip-select pulse and scores it against the model.
  logic [NUM_CHIPS-1:0] prev_cs_n = '1;
  int                   low_len = 0;
  wr_t                  got, want;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs_n = '1;
      low_len   = 0;
    end else begin
      check("rw_tracks_cs", 32'(sid_rw), 32'(sid_cs_n == '1));
      if (sid_cs_n != '1 && prev_cs_n == '1) begin
        got.chip = 2'd0;
        for (int c = 0; c < NUM_CHIPS; c++) if (!sid_cs_n[c]) got.chip = 2'(c);
        got.addr = sid_addr;
        got.data = sid_data;
        check("one_cs_low", 32'($countones(~sid_cs_n)), 32'd1);
        check("start_at_phi_fall", 32'(sid_clk), 32'd0);
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          check("write_chip", 32'(got.chip), 32'(want.chip));
          check("write_addr", 32'(got.addr), 32'(want.addr));
          check("write_data", 32'(got.data), 32'(want.data));
        end
        obs_q.push_back(got);
        low_len = 1;
      end else if (sid_cs_n != '1) begin
        low_len++;
      end else if (prev_cs_n != '1) begin
        check("cs_low_len", 32'(low_len), 32'(WR_LEN));
      end
      prev_cs_n = sid_cs_n;
    end
  end

  // Send nbytes from fbuf; frame_end either with the last byte or after it.
  task automatic send_frame(input int nbytes, input bit merge_end, input bit exp_short,
                            input bit exp_drop, input bit accept);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = fbuf[i];
      frame_end  = merge_end && (i == nbytes - 1);
    end
    if (!merge_end) begin
      @(negedge clk);
      byte_valid = 1'b0;
      frame_end  = 1'b1;
    end
    @(posedge clk); #1;
    check("frame_short", 32'(frame_short), 32'(exp_short));
    check("frame_drop", 32'(frame_drop), 32'(exp_drop));
    check("busy_after_end", 32'(busy), 32'(accept || exp_drop));
    if (accept) model_accept();
    @(negedge clk);
    byte_valid = 1'b0;
    frame_end  = 1'b0;
    @(posedge clk); #1;
    check("short_one_cycle", 32'(frame_short), 32'd0);
    check("drop_one_cycle", 32'(frame_drop), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_within_budget", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_sid_reset(input int budget);
    int n = 0;
    while (!sid_rst_n && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("sid_rst_released", 32'(sid_rst_n), 32'd1);
  endtask

  initial begin
    int n;
    wr_t pin;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_sid_clk", 32'(sid_clk), 32'd0);
    check("rst_addr", 32'(sid_addr), 32'd0);
    check("rst_data", 32'(sid_data), 32'd0);
    check("rst_cs_n", 32'(sid_cs_n), 32'h3);
    check("rst_rw", 32'(sid_rw), 32'd1);
    check("rst_sid_rst_n", 32'(sid_rst_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(frame_drop), 32'd0);
    check("rst_short", 32'(frame_short), 32'd0);

    // SID reset released exactly 16 phi2 periods (128 clk) after release.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CLK_DIV * RST_PHI_CYCLES - 1) @(posedge clk);
    #1;
    check("sid_rst_n_held", 32'(sid_rst_n), 32'd0);
    check("cs_idle_in_sid_rst", 32'(sid_cs_n), 32'h3);
    @(posedge clk); #1;
    check("sid_rst_n_release", 32'(sid_rst_n), 32'd1);

    // Full frame 0x00..0x31: all 50 registers in chip-major order.
    for (int i = 0; i < FRAME; i++) fbuf[i] = 8'(i);
    obs_q.delete();
    send_frame(FRAME, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(2000);
    check("f1_count", 32'(obs_q.size()), 32'd50);
    if (obs_q.size() == 50) begin
      pin = mk(0, 0, 8'h00);
      check("f1_first", 32'(obs_q[0]), 32'(pin));
      pin = mk(0, 24, 8'h18);
      check("f1_chip0_last", 32'(obs_q[24]), 32'(pin));
      pin = mk(1, 0, 8'h19);
      check("f1_chip1_first", 32'(obs_q[25]), 32'(pin));
      pin = mk(1, 24, 8'h31);
      check("f1_last", 32'(obs_q[49]), 32'(pin));
    end

    // Same frame again.
    obs_q.delete();
    send_frame(FRAME, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(2000);
    check("same_count", 32'(obs_q.size()), DELTA ? 32'd0 : 32'd50);

    // Only byte 30 changed -> chip 1, register 5.
    fbuf[30] = 8'hAA;
    obs_q.delete();
    send_frame(FRAME, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(2000);
    check("one_change_count", 32'(obs_q.size()), DELTA ? 32'd1 : 32'd50);
    n = DELTA ? 0 : 30;
    if (obs_q.size() > n) begin
      pin = mk(1, 5, 8'hAA);
      check("one_change_write", 32'(obs_q[n]), 32'(pin));
    end

    // 49-byte frame: short pulse, nothing written.
    for (int i = 0; i < FRAME; i++) fbuf[i] = 8'h55;
    obs_q.delete();
    send_frame(FRAME - 1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("short_no_busy", 32'(busy), 32'd0);
    check("short_no_writes", 32'(obs_q.size()), 32'd0);

    // Full frame whose frame_end coincides with the last byte.
    for (int i = 0; i < FRAME; i++) fbuf[i] = 8'(i * 3);
    obs_q.delete();
    send_frame(FRAME, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle(2000);
    check("merged_end_count", 32'(obs_q.size()), 32'(m_pushed));

    // 52-byte frame (extra bytes ignored), then a frame dropped while busy.
    for (int i = 0; i < FRAME; i++) fbuf[i] = 8'(i ^ 8'hFF);
    fbuf[50] = 8'h11;
    fbuf[51] = 8'h22;
    obs_q.delete();
    send_frame(FRAME + 2, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < FRAME; i++) fbuf[i] = 8'h77;
    send_frame(FRAME, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle(2000);
    check("drop_seq_count", 32'(obs_q.size()), 32'd50);
    if (obs_q.size() == 50) begin
      pin = mk(1, 24, 8'hCE);
      check("drop_seq_last", 32'(obs_q[49]), 32'(pin));
    end

    // Reset asserted during HOLD: selects release immediately.
    for (int i = 0; i < FRAME; i++) fbuf[i] = 8'(i + 8'h40);
    obs_q.delete();
    send_frame(FRAME, 1'b0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (sid_cs_n == '1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("write_started", 32'(sid_cs_n != '1), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cs_n", 32'(sid_cs_n), 32'h3);
    check("arst_rw", 32'(sid_rw), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_sid_rst_n", 32'(sid_rst_n), 32'd0);
    exp_q.delete();
    m_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sid_reset(300);
    obs_q.delete();
    send_frame(FRAME, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(2000);
    check("after_reset_count", 32'(obs_q.size()), 32'd50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
